// File: rtl/lifo_ctrl_pkg.sv
// Shared encodings for the return-address LIFO sequencer: request opcodes and controller states.
package lifo_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_SWAP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SWAP2 = 2'b01,
        FLUSH = 2'b10
    } state_e;

endpackage

// File: rtl/lifo_ctrl.sv
// Sequencer for the shift-register return-address LIFO: PUSH/POP/SWAP handshake, occupancy, error flags, flush.
// Optional: define LIFO_CTRL_OVERWRITE_EN to let a PUSH while full overwrite (bottom entry drops out).
module lifo_ctrl
    import lifo_ctrl_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_data,
    input  logic          flush,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          lifo_en,
    output logic          lifo_push,
    output logic [DW-1:0] lifo_din,
    input  logic [DW-1:0] lifo_dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          err_ovf,
    output logic          err_unf
);

    state_e        r_state;
    logic [CW-1:0] r_drain;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_swap_data;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_data;
    logic          r_err_ovf;
    logic          r_err_unf;

    op_e           w_op;
    logic          w_full;
    logic          w_empty;
    logic          w_overwrite;

    assign w_op    = op_e'(req_op);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

`ifdef LIFO_CTRL_OVERWRITE_EN
    assign w_overwrite = 1'b1;
`else
    assign w_overwrite = 1'b0;
`endif

    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign err_ovf   = r_err_ovf;
    assign err_unf   = r_err_unf;

    // LIFO strobes are combinational so an accepted request reaches the LIFO in the same cycle.
    always_comb begin
        req_ready = 1'b0;
        lifo_en   = 1'b0;
        lifo_push = 1'b0;
        lifo_din  = '0;
        case (r_state)
            FLUSH: begin
                lifo_en = 1'b1;
            end
            SWAP2: begin
                lifo_en   = 1'b1;
                lifo_push = 1'b1;
                lifo_din  = r_swap_data;
            end
            default: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    case (w_op)
                        OP_PUSH: begin
                            lifo_en   = !w_full || w_overwrite;
                            lifo_push = 1'b1;
                            lifo_din  = req_data;
                        end
                        OP_POP: begin
                            lifo_en = !w_empty;
                        end
                        OP_SWAP: begin
                            lifo_en   = 1'b1;
                            lifo_push = w_empty;
                            lifo_din  = req_data;
                        end
                        default: begin
                            lifo_en = 1'b0;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FLUSH;
            r_drain     <= CW'(DEPTH);
            r_count     <= '0;
            r_swap_data <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_err_ovf   <= 1'b0;
            r_err_unf   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_unf   <= 1'b0;
            case (r_state)
                FLUSH: begin
                    if (r_drain != '0) begin
                        r_drain <= r_drain - CW'(1);
                    end
                    if (!w_empty) begin
                        r_count <= r_count - CW'(1);
                    end
                    if (r_drain <= CW'(1)) begin
                        r_state <= IDLE;
                    end
                end
                SWAP2: begin
                    if (!w_full) begin
                        r_count <= r_count + CW'(1);
                    end
                    r_state <= IDLE;
                end
                default: begin
                    if (flush) begin
                        r_drain <= r_count;
                        if (!w_empty) begin
                            r_state <= FLUSH;
                        end
                    end else if (req_valid) begin
                        case (w_op)
                            OP_PUSH: begin
                                if (w_full) begin
                                    r_err_ovf <= 1'b1;
                                end else begin
                                    r_count <= r_count + CW'(1);
                                end
                            end
                            OP_POP: begin
                                r_rsp_valid <= 1'b1;
                                if (w_empty) begin
                                    r_rsp_data <= '0;
                                    r_err_unf  <= 1'b1;
                                end else begin
                                    r_rsp_data <= lifo_dout;
                                    r_count    <= r_count - CW'(1);
                                end
                            end
                            OP_SWAP: begin
                                r_rsp_valid <= 1'b1;
                                // Swapping an empty stack degenerates into a plain push.
                                if (w_empty) begin
                                    r_rsp_data <= '0;
                                    r_err_unf  <= 1'b1;
                                    r_count    <= r_count + CW'(1);
                                end else begin
                                    r_rsp_data  <= lifo_dout;
                                    r_swap_data <= req_data;
                                    r_count     <= r_count - CW'(1);
                                    r_state     <= SWAP2;
                                end
                            end
                            default: begin
                                r_count <= r_count;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_ctrl.sv
// Self-checking bench for lifo_ctrl: directed scenarios plus randomized traffic against a queue-based stack model.
module tb_lifo_ctrl;
    import lifo_ctrl_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef LIFO_CTRL_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_data;
    logic          flush;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          lifo_en;
    logic          lifo_push;
    logic [DW-1:0] lifo_din;
    logic [DW-1:0] lifo_dout;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          err_ovf;
    logic          err_unf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lifo_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .flush(flush), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .lifo_en(lifo_en), .lifo_push(lifo_push), .lifo_din(lifo_din), .lifo_dout(lifo_dout),
        .count(count), .full(full), .empty(empty), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    // Physical shift-register LIFO sitting beside the controller; starts with garbage.
    logic [DW-1:0] lifo_mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) lifo_mem[i] = 8'hA5 + 8'(i);
    always @(posedge clk) begin
        if (lifo_en) begin
            if (lifo_push) begin
                for (int i = DEPTH - 1; i > 0; i--) lifo_mem[i] <= lifo_mem[i-1];
                lifo_mem[0] <= lifo_din;
            end else begin
                for (int i = 0; i < DEPTH - 1; i++) lifo_mem[i] <= lifo_mem[i+1];
                lifo_mem[DEPTH-1] <= '0;
            end
        end
    end
    assign lifo_dout = lifo_mem[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: logical stack contents (front = top), plus cycles the controller is busy.
    logic [DW-1:0] m_stk [$];
    int            m_busy = 0;
    bit            m_swap_mode = 0;
    logic [DW-1:0] m_pend = '0;
    logic [DW-1:0] m_rsp_data = '0;
    bit            m_rv = 0, m_ovf = 0, m_unf = 0;
    bit            m_init = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_stk.delete();
            m_busy = DEPTH; m_swap_mode = 0;
            m_rsp_data = '0; m_rv = 0; m_ovf = 0; m_unf = 0;
            m_init = 1;
        end else if (m_init) begin
            m_rv = 0; m_ovf = 0; m_unf = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_swap_mode) begin
                    m_stk.push_front(m_pend);
                    m_swap_mode = 0;
                end else if (m_stk.size() > 0) begin
                    void'(m_stk.pop_front());
                end
            end else if (flush) begin
                m_busy = m_stk.size();
            end else if (req_valid) begin
                case (op_e'(req_op))
                    OP_PUSH: begin
                        if (m_stk.size() < DEPTH) m_stk.push_front(req_data);
                        else begin
                            m_ovf = 1;
                            if (OVW) begin
                                m_stk.push_front(req_data);
                                void'(m_stk.pop_back());
                            end
                        end
                    end
                    OP_POP: begin
                        m_rv = 1;
                        if (m_stk.size() > 0) m_rsp_data = m_stk.pop_front();
                        else begin m_rsp_data = '0; m_unf = 1; end
                    end
                    OP_SWAP: begin
                        m_rv = 1;
                        if (m_stk.size() > 0) begin
                            m_rsp_data = m_stk.pop_front();
                            m_pend = req_data; m_swap_mode = 1; m_busy = 1;
                        end else begin
                            m_rsp_data = '0; m_unf = 1;
                            m_stk.push_front(req_data);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    bit            e_ready, e_en, e_push, e_din_chk;
    logic [DW-1:0] e_din;

    always @(negedge clk) begin
        if (!reset && m_init) begin
            e_ready = (m_busy == 0) && !flush;
            e_en = 0; e_push = 0; e_din = '0; e_din_chk = 0;
            if (m_busy > 0) begin
                e_en = 1; e_push = m_swap_mode; e_din_chk = 1;
                e_din = m_swap_mode ? m_pend : '0;
            end else if (e_ready && req_valid) begin
                case (op_e'(req_op))
                    OP_PUSH: begin
                        e_en = (m_stk.size() < DEPTH) || OVW; e_push = 1;
                        e_din = req_data; e_din_chk = 1;
                    end
                    OP_POP: e_en = (m_stk.size() > 0);
                    OP_SWAP: begin
                        e_en = 1; e_push = (m_stk.size() == 0);
                        e_din = req_data; e_din_chk = e_push;
                    end
                    default: e_en = 0;
                endcase
            end
            chk("req_ready", req_ready, e_ready);
            chk("lifo_en", lifo_en, e_en);
            if (e_en) chk("lifo_push", lifo_push, e_push);
            if (e_en && e_din_chk) chk("lifo_din", lifo_din, e_din);
            chk("count", count, m_stk.size());
            chk("full", full, m_stk.size() == DEPTH);
            chk("empty", empty, m_stk.size() == 0);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_data", rsp_data, m_rsp_data);
            chk("err_ovf", err_ovf, m_ovf);
            chk("err_unf", err_unf, m_unf);
        end
    end

    // All driving happens just after a rising edge; tasks return at that same phase.
    task automatic do_req(input logic [1:0] op, input logic [DW-1:0] data, output int waited);
        bit r;
        req_valid = 1; req_op = op; req_data = data; waited = 0;
        forever begin
            @(negedge clk); r = req_ready;
            @(posedge clk); #1;
            if (r) break;
            waited++;
            if (waited > 20) begin
                n_checks++; n_fail++;
                $display("FAIL handshake_timeout: got no req_ready expected req_ready within 20 cycles");
                break;
            end
        end
        req_valid = 0; req_op = 2'b00;
        $display("req op=%0d data=%02h waited=%0d", op, data, waited);
    endtask

    task automatic push(input logic [DW-1:0] d);
        int w;
        do_req(OP_PUSH, d, w);
    endtask

    task automatic pop_chk(input logic [DW-1:0] exp);
        int w;
        do_req(OP_POP, '0, w);
        @(negedge clk);
        chk("pop_valid", rsp_valid, 1);
        chk("pop_data", rsp_data, exp);
        $display("pop data=%02h exp=%02h", rsp_data, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        reset = 1; req_valid = 0; req_op = 0; req_data = 0; flush = 0;
        @(posedge clk); #1;
        reset = 0;

        // 1: post-reset flush takes DEPTH cycles
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("t1_en", lifo_en, 1);
            chk("t1_push", lifo_push, 0);
            chk("t1_ready", req_ready, 0);
        end
        @(negedge clk);
        chk("t1_ready_after", req_ready, 1);
        chk("t1_count", count, 0);
        chk("t1_empty", empty, 1);
        chk("t1_lifo_clear", lifo_dout, 0);
        @(posedge clk); #1;

        // 2: fill then drain
        push(8'h11); push(8'h22); push(8'h33);
        @(negedge clk);
        chk("t2_count", count, 3);
        chk("t2_full", full, 1);
        @(posedge clk); #1;
        pop_chk(8'h33); pop_chk(8'h22); pop_chk(8'h11);
        @(negedge clk);
        chk("t2_empty", empty, 1);
        @(posedge clk); #1;

        // 3: push while full
        push(8'h11); push(8'h22); push(8'h33);
        req_valid = 1; req_op = OP_PUSH; req_data = 8'h44;
        @(negedge clk);
        chk("t3_en", lifo_en, OVW);
        @(posedge clk); #1;
        req_valid = 0; req_op = 0;
        @(negedge clk);
        chk("t3_ovf", err_ovf, 1);
        chk("t3_count", count, 3);
        @(posedge clk); #1;
        if (OVW) begin
            pop_chk(8'h44); pop_chk(8'h33); pop_chk(8'h22);
        end else begin
            pop_chk(8'h33); pop_chk(8'h22); pop_chk(8'h11);
        end

        // 4: pop while empty
        req_valid = 1; req_op = OP_POP;
        @(negedge clk);
        chk("t4_en", lifo_en, 0);
        @(posedge clk); #1;
        req_valid = 0; req_op = 0;
        @(negedge clk);
        chk("t4_valid", rsp_valid, 1);
        chk("t4_data", rsp_data, 0);
        chk("t4_unf", err_unf, 1);
        chk("t4_count", count, 0);
        @(posedge clk); #1;

        // 5: swap replaces the top
        push(8'h11); push(8'h22);
        do_req(OP_SWAP, 8'h55, w);
        @(negedge clk);
        chk("t5_data", rsp_data, 8'h22);
        chk("t5_valid", rsp_valid, 1);
        chk("t5_ready", req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_ready_back", req_ready, 1);
        chk("t5_count", count, 2);
        @(posedge clk); #1;
        pop_chk(8'h55); pop_chk(8'h11);

        // 6: flush outranks a pending push
        push(8'h11); push(8'h22);
        flush = 1; req_valid = 1; req_op = OP_PUSH; req_data = 8'h66;
        @(negedge clk);
        chk("t6_ready", req_ready, 0);
        @(posedge clk); #1;
        flush = 0;
        do_req(OP_PUSH, 8'h66, w);
        chk("t6_wait", w, 2);
        @(negedge clk);
        chk("t6_count", count, 1);
        @(posedge clk); #1;
        pop_chk(8'h66);

        // Randomized traffic, including flushes and resets at arbitrary points
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 249) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = 2'($urandom_range(0, 3));
            req_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        reset = 0; flush = 0; req_valid = 0; req_op = 0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
